// File: rtl/risk_pkg.sv
// Shared definitions for the ID/EX hazard-control stage: state encodings, default
// widths, control-bundle field positions and the RUN-state request arbiter.
package risk_pkg;

    localparam int CTRL_W_DEF = 24;
    localparam int CNT_W_DEF  = 4;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
    localparam logic [1:0] ST_RSVD  = 2'd3;

    // Bit positions of the fields inside the decoded control bundle.
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_ALU_OP_LO = 3;
    localparam int CTRL_ALU_OP_HI = 6;
    localparam int CTRL_BRANCH    = 7;
    localparam int CTRL_JUMP      = 8;

    typedef enum logic [2:0] {
        ACT_NORMAL = 3'd0,
        ACT_FLUSH  = 3'd1,
        ACT_HALT   = 3'd2,
        ACT_STALL  = 3'd3,
        ACT_RISK   = 3'd4
    } run_act_e;

    // A zero-length stall request degenerates into a plain load-use bubble.
    function automatic run_act_e decode_run_act(input logic flush, input logic halt,
                                                input logic stall_req, input logic stall_len_nz,
                                                input logic risk);
        run_act_e act;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (halt) begin
            act = ACT_HALT;
        end else if (stall_req && stall_len_nz) begin
            act = ACT_STALL;
        end else if (stall_req || risk) begin
            act = ACT_RISK;
        end else begin
            act = ACT_NORMAL;
        end
        return act;
    endfunction

endpackage

// File: rtl/risk_stall_counter.sv
// Down-counter for multi-cycle stalls: load, clear, decrement with no wrap, last flag.
module risk_stall_counter
    import risk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last
);

    logic [CNT_W-1:0] count_r;

    // Counter register; clear beats load beats decrement, and zero never decrements.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (i_load) begin
            count_r <= i_load_val;
        end else if (i_dec && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign o_count = count_r;
    assign o_last  = (count_r == CNT_W'(1));

endmodule

// File: rtl/risk_ctrl_stage.sv
// ID/EX control register with hazard handling: flush, halt, load-use and
// multi-cycle stall bubbles, plus PC / IF-ID write enables.
module risk_ctrl_stage
    import risk_pkg::*;
#(
    parameter int                CTRL_W    = CTRL_W_DEF,
    parameter int                CNT_W     = CNT_W_DEF,
    parameter logic [CTRL_W-1:0] KEEP_MASK = {CTRL_W{1'b0}}
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_halt,
    input  logic              i_risk,
    input  logic              i_stall_req,
    input  logic [CNT_W-1:0]  i_stall_len,
    input  logic              i_flush,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_halt,
    output logic              o_pc_write,
    output logic              o_ifid_write,
    output logic              o_bubble,
    output logic [1:0]        o_state
);

    logic [1:0]        state_r, state_nxt_s;
    logic [CTRL_W-1:0] ctrl_r, ctrl_nxt_s;
    logic              bubble_r, bubble_nxt_s;
    logic              halt_r, halt_nxt_s;
    logic              wr_en_s;
    logic              cnt_load_s, cnt_dec_s, cnt_clr_s, cnt_last_s;
    logic [CNT_W-1:0]  cnt_s;
    run_act_e          act_s;

    assign act_s = decode_run_act(i_flush, i_halt, i_stall_req,
                                  (i_stall_len != {CNT_W{1'b0}}), i_risk);

    risk_stall_counter #(.CNT_W(CNT_W)) u_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (cnt_load_s),
        .i_load_val (i_stall_len),
        .i_dec      (cnt_dec_s),
        .i_clr      (cnt_clr_s),
        .o_count    (cnt_s),
        .o_last     (cnt_last_s)
    );

    // Next-state, next-control and write-enable decode; a frozen stage holds everything.
    always_comb begin
        state_nxt_s  = state_r;
        ctrl_nxt_s   = ctrl_r;
        bubble_nxt_s = bubble_r;
        halt_nxt_s   = halt_r;
        wr_en_s      = 1'b0;
        cnt_load_s   = 1'b0;
        cnt_dec_s    = 1'b0;
        cnt_clr_s    = 1'b0;
        if (i_enable) begin
            case (state_r)
                ST_RUN: begin
                    case (act_s)
                        ACT_FLUSH: begin
                            ctrl_nxt_s   = {CTRL_W{1'b0}};
                            bubble_nxt_s = 1'b1;
                            wr_en_s      = 1'b1;
                        end
                        ACT_HALT: begin
                            ctrl_nxt_s   = i_ctrl;
                            bubble_nxt_s = 1'b0;
                            halt_nxt_s   = 1'b1;
                            state_nxt_s  = ST_HALT;
                        end
                        ACT_STALL: begin
                            ctrl_nxt_s   = {CTRL_W{1'b0}};
                            bubble_nxt_s = 1'b1;
                            cnt_load_s   = 1'b1;
                            state_nxt_s  = ST_STALL;
                        end
                        ACT_RISK: begin
                            ctrl_nxt_s   = i_ctrl & KEEP_MASK;
                            bubble_nxt_s = 1'b1;
                        end
                        default: begin
                            ctrl_nxt_s   = i_ctrl;
                            bubble_nxt_s = 1'b0;
                            wr_en_s      = 1'b1;
                        end
                    endcase
                end
                ST_STALL: begin
                    ctrl_nxt_s   = {CTRL_W{1'b0}};
                    bubble_nxt_s = 1'b1;
                    if (i_flush) begin
                        cnt_clr_s   = 1'b1;
                        wr_en_s     = 1'b1;
                        state_nxt_s = ST_RUN;
                    end else begin
                        cnt_dec_s   = 1'b1;
                        state_nxt_s = cnt_last_s ? ST_RUN : ST_STALL;
                    end
                end
                ST_HALT: begin
                    ctrl_nxt_s   = {CTRL_W{1'b0}};
                    bubble_nxt_s = 1'b1;
                    halt_nxt_s   = 1'b1;
                end
                default: begin
                    ctrl_nxt_s   = {CTRL_W{1'b0}};
                    bubble_nxt_s = 1'b1;
                    cnt_clr_s    = 1'b1;
                    state_nxt_s  = ST_RUN;
                end
            endcase
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Pipeline register for state, control bundle and status flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_RUN;
            ctrl_r   <= {CTRL_W{1'b0}};
            bubble_r <= 1'b0;
            halt_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            ctrl_r   <= ctrl_nxt_s;
            bubble_r <= bubble_nxt_s;
            halt_r   <= halt_nxt_s;
        end
    end

    assign o_ctrl       = ctrl_r;
    assign o_halt       = halt_r;
    assign o_bubble     = bubble_r;
    assign o_state      = state_r;
    assign o_pc_write   = wr_en_s & i_rst_n;
    assign o_ifid_write = wr_en_s & i_rst_n;

endmodule

// File: doc/risk_ctrl_stage.md
RISK_CTRL_STAGE -- requirements
Module: risk_ctrl_stage

Interface
REQ-001 SHALL use one clock i_clk; reset is asynchronous and active-low, i_rst_n.
REQ-002 Param CTRL_W, default 24, width of decoded control bundle.
REQ-003 Param CNT_W, default 4, width of stall-length field and counter.
REQ-004 Param KEEP_MASK, default {CTRL_W{1'b0}}, control bits preserved during load-use bubbles.
REQ-005 i_clk  in  1  pipeline clock.
REQ-006 i_rst_n  in  1  async active-low reset.
REQ-007 i_enable  in  1  pipeline advance (debug step/run); low freezes block.
REQ-008 i_ctrl  in  CTRL_W  control bundle from control unit.
REQ-009 i_halt  in  1  decoded HALT in ID.
REQ-010 i_risk  in  1  load-use hazard, one bubble.
REQ-011 i_stall_req  in  1  multi-cycle stall request.
REQ-012 i_stall_len  in  CNT_W  extra bubble cycles requested with i_stall_req.
REQ-013 i_flush  in  1  taken branch/jump, squash ID.
REQ-014 o_ctrl  out  CTRL_W  registered ID/EX control bundle.
REQ-015 o_halt  out  1  sticky halted flag.
REQ-016 o_pc_write  out  1  PC update enable (combinational).
REQ-017 o_ifid_write  out  1  IF/ID update enable (combinational).
REQ-018 o_bubble  out  1  registered; o_ctrl currently holds an inserted bubble.
REQ-019 o_state  out  2  current FSM state.

Function
REQ-020 States SHALL be RUN=0, STALL=1, HALT=2; encoding 3 unused, recovers to RUN.
REQ-021 o_ctrl SHALL update one cycle after the enabled edge capturing the request (latency 1).
REQ-022 i_enable low: state, counter, o_ctrl, o_bubble held; o_pc_write=o_ifid_write=0.
REQ-023 RUN priority SHALL be i_flush > i_halt > i_stall_req > i_risk > normal.
REQ-024 RUN+i_flush: o_ctrl<=0, o_bubble<=1, o_pc_write=1, o_ifid_write=1, stay RUN.
REQ-025 RUN+i_halt: o_ctrl<=i_ctrl, o_halt<=1, o_pc_write=0, o_ifid_write=0, go HALT.
REQ-026 RUN+i_stall_req, i_stall_len=L>0: o_ctrl<=0, o_bubble<=1, counter<=L, pc/ifid write 0, go STALL.
REQ-027 RUN+i_stall_req with L=0 SHALL behave exactly as i_risk.
REQ-028 RUN+i_risk: o_ctrl<=i_ctrl & KEEP_MASK, o_bubble<=1, pc/ifid write 0, stay RUN.
REQ-029 RUN normal: o_ctrl<=i_ctrl, o_bubble<=0, pc/ifid write 1.
REQ-030 STALL: each enabled cycle o_ctrl<=0, o_bubble<=1, counter decrements, pc/ifid write 0; counter=1 -> RUN; total bubbles = L+1.
REQ-031 STALL+i_flush: counter<=0, o_ctrl<=0, pc/ifid write 1, go RUN; i_halt, i_risk, i_stall_req ignored in STALL.
REQ-032 HALT: o_ctrl<=0, o_bubble<=1, pc/ifid write 0, o_halt=1; all requests incl. i_flush ignored; exit only by reset.
REQ-033 Counter SHALL never wrap; decrement from 0 is not possible by construction.

Reset
REQ-034 i_rst_n low SHALL immediately force o_ctrl=0, o_halt=0, o_bubble=0, counter=0, state RUN.
REQ-035 While i_rst_n low, o_pc_write=o_ifid_write=0; reset mid-STALL or in HALT discards all pending state.

Structure
REQ-036 State encodings, default CTRL_W/CNT_W and control-bundle field index constants SHALL live in shared package risk_pkg.
REQ-037 Stall counter SHALL be sub-module risk_stall_counter (load, decrement-on-enable, last flag).

Verification (CTRL_W=24, CNT_W=4, KEEP_MASK=0)
REQ-038 Normal: i_ctrl=24'hA5A5A5, enable=1 -> next cycle o_ctrl=24'hA5A5A5, o_bubble=0, pc/ifid write 1.
REQ-039 Load-use: i_risk=1 one cycle, i_ctrl=24'h00FFFF -> o_ctrl=0, o_bubble=1, pc/ifid write 0 that cycle; KEEP_MASK=24'h000001 -> o_ctrl=24'h000001.
REQ-040 Stall: i_stall_req=1, i_stall_len=3 -> exactly 4 bubble cycles, o_state=1 for 3 cycles, then RUN; i_flush on 2nd STALL cycle -> RUN next cycle, o_pc_write=1.
REQ-041 Priority: i_flush=i_halt=i_risk=1 simultaneously -> flush wins, o_halt stays 0; then i_halt alone -> o_halt=1, o_state=2, later i_flush ignored.
REQ-042 Freeze/reset: i_enable=0 mid-STALL holds counter for 5 cycles; i_rst_n pulsed low mid-STALL -> o_ctrl=0, o_state=0 asynchronously.
